// File: rtl/stream_mux_pkg.sv
// Shared definitions for stream_mux_rr: mode constants, lock state
// encoding and the wrapping pointer increment used by round-robin.
// Optional packet lock is enabled by defining STREAM_MUX_PKT_LOCK_EN.
package stream_mux_pkg;

    localparam int MODE_SEL = 0;   // external channel select
    localparam int MODE_RR  = 1;   // internal round-robin arbitration

    // Packet lock state: OPEN arbitrates per beat, HELD pins the grant.
    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

    // Increment a channel index, wrapping n-1 back to 0.
    function automatic logic [31:0] rr_next(input logic [31:0] ptr, input logic [31:0] n);
        return ((ptr + 32'd1) >= n) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches requests starting at the
// pointer and wrapping modulo N; the first requester wins. The pointer
// register itself is owned by the caller.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_vld
);

    // Rotating priority search: first request at or after i_ptr wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = |i_req;
        found       = 1'b0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((32'(i_ptr) + 32'(k)) % 32'(N));
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant_idx  = idx;
                o_grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with one registered output
// stage. Channel choice is either the external sel input (MODE=0) or
// round-robin arbitration (MODE=1). Define STREAM_MUX_PKT_LOCK_EN to add
// in_last/out_last and hold the grant on one channel for a whole packet.
//
// Handshake: a beat moves on channel i when in_valid[i] && in_ready[i],
// and leaves the output when out_valid && out_ready. in_ready is only
// ever raised on the granted channel, and only when the output register
// is empty or draining in the same cycle, so throughput is 1 beat/cycle.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = 1,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [N_CH*DATA_W-1:0] in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [N_CH-1:0]        in_last,
`endif
    input  logic [SEL_W-1:0]       sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
    output logic                   out_last,
`endif
    output logic [SEL_W-1:0]       out_ch
);

    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_out_data;
    logic [SEL_W-1:0]      r_out_ch;

    logic                  w_load_en;
    logic                  w_xfer;
    logic [N_CH-1:0]       w_pick_oh;
    logic [SEL_W-1:0]      w_pick_idx;
    logic                  w_pick_vld;
    logic [N_CH-1:0]       w_grant_oh;
    logic [SEL_W-1:0]      w_grant_idx;
    logic                  w_grant_vld;
    logic [DATA_W-1:0]     w_grant_data;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_xfer    = !rst && w_load_en && w_grant_vld;

    generate
        if (MODE == MODE_SEL) begin : g_sel
            // External select: out-of-range sel matches no channel.
            always_comb begin
                w_pick_oh  = '0;
                w_pick_vld = 1'b0;
                w_pick_idx = sel;
                for (int i = 0; i < N_CH; i++) begin
                    if (sel == SEL_W'(i)) begin
                        w_pick_oh[i] = 1'b1;
                        w_pick_vld   = in_valid[i];
                    end
                end
            end
        end else begin : g_rr
            logic [SEL_W-1:0] r_ptr;

            rr_arbiter #(
                .N     (N_CH),
                .IDX_W (SEL_W)
            ) u_arb (
                .i_req       (in_valid),
                .i_ptr       (r_ptr),
                .o_grant     (w_pick_oh),
                .o_grant_idx (w_pick_idx),
                .o_grant_vld (w_pick_vld)
            );

            // Pointer moves past the winner only when a beat is taken.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_xfer) begin
                    r_ptr <= SEL_W'(rr_next(32'(w_grant_idx), 32'(N_CH)));
                end
            end
        end
    endgenerate

`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_state_e      r_lock_state;
    logic [SEL_W-1:0] r_lock_ch;
    logic             r_out_last;
    logic             w_grant_last;

    // While a packet is open the grant is pinned to the locked channel.
    always_comb begin
        w_grant_oh  = w_pick_oh;
        w_grant_idx = w_pick_idx;
        w_grant_vld = w_pick_vld;
        if (r_lock_state == LK_HELD) begin
            w_grant_oh  = '0;
            w_grant_idx = r_lock_ch;
            w_grant_vld = 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                if (r_lock_ch == SEL_W'(i)) begin
                    w_grant_oh[i] = 1'b1;
                    w_grant_vld   = in_valid[i];
                end
            end
        end
    end

    // Last flag of the granted channel.
    always_comb begin
        w_grant_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_grant_last = in_last[i];
            end
        end
    end

    // Lock FSM: a non-last beat opens/keeps a packet, a last beat closes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_state <= LK_OPEN;
            r_lock_ch    <= '0;
        end else if (w_xfer) begin
            if (w_grant_last) begin
                r_lock_state <= LK_OPEN;
            end else begin
                r_lock_state <= LK_HELD;
                r_lock_ch    <= w_grant_idx;
            end
        end
    end

    // Last flag travels with the data in the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_last <= 1'b0;
        end else if (w_xfer) begin
            r_out_last <= w_grant_last;
        end
    end

    assign out_last = r_out_last;
`else
    assign w_grant_oh  = w_pick_oh;
    assign w_grant_idx = w_pick_idx;
    assign w_grant_vld = w_pick_vld;
`endif

    // Data of the granted channel.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_grant_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready only on the granted channel, and never while in reset.
    always_comb begin
        in_ready = '0;
        if (!rst && w_load_en && w_grant_vld) begin
            in_ready = w_grant_oh;
        end
    end

    // Output register: load on free/draining slot, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_grant_data;
                r_out_ch   <= w_grant_idx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a round-robin instance (N_CH=4) and an
// external-select instance (N_CH=3) run side by side against a
// transaction-level reference model, with directed scenarios followed
// by randomized traffic. Honors STREAM_MUX_PKT_LOCK_EN.
module tb_stream_mux_rr;

`ifdef STREAM_MUX_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;

    logic [3:0]  rr_valid, rr_ready, rr_last, rr_acc;
    logic [31:0] rr_data;
    logic [1:0]  rr_sel, rr_och;
    logic        rr_ovalid, rr_oready, rr_olast;
    logic [7:0]  rr_odata;

    logic [2:0]  sl_valid, sl_ready, sl_last, sl_acc;
    logic [23:0] sl_data;
    logic [1:0]  sl_sel, sl_och;
    logic        sl_ovalid, sl_oready, sl_olast;
    logic [7:0]  sl_odata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = round-robin DUT, 1 = select DUT.
    bit         m_ov[2];
    logic [7:0] m_od[2];
    int         m_oc[2];
    bit         m_ol[2];
    int         m_ptr[2];
    bit         m_locked[2];
    int         m_lock_ch[2];

    stream_mux_rr #(.N_CH(4), .DATA_W(8), .MODE(1)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rr_valid),
        .in_ready  (rr_ready),
        .in_data   (rr_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last   (rr_last),
        .out_last  (rr_olast),
`endif
        .sel       (rr_sel),
        .out_valid (rr_ovalid),
        .out_ready (rr_oready),
        .out_data  (rr_odata),
        .out_ch    (rr_och)
    );

    stream_mux_rr #(.N_CH(3), .DATA_W(8), .MODE(0)) u_sel (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (sl_valid),
        .in_ready  (sl_ready),
        .in_data   (sl_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last   (sl_last),
        .out_last  (sl_olast),
`endif
        .sel       (sl_sel),
        .out_valid (sl_ovalid),
        .out_ready (sl_oready),
        .out_data  (sl_odata),
        .out_ch    (sl_och)
    );

`ifndef STREAM_MUX_PKT_LOCK_EN
    assign rr_olast = 1'b0;
    assign sl_olast = 1'b0;
`endif

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 1'b0; m_od[d] = 8'h00; m_oc[d] = 0; m_ol[d] = 1'b0;
            m_ptr[d] = 0; m_locked[d] = 1'b0; m_lock_ch[d] = 0;
        end
    endfunction

    // Which channel the rules say wins this cycle.
    function automatic void model_grant(input int d, input logic [3:0] v, input int s,
                                        output int g, output bit gv);
        int n;
        n  = (d == 0) ? 4 : 3;
        g  = 0;
        gv = 1'b0;
        if (m_locked[d]) begin
            g  = m_lock_ch[d];
            gv = v[g];
        end else if (d == 0) begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (m_ptr[d] + k) % n;
                if (!gv && v[c]) begin
                    g  = c;
                    gv = 1'b1;
                end
            end
        end else if (s < n) begin
            g  = s;
            gv = v[s];
        end
    endfunction

    function automatic void model_take(input int d, input bit x, input int g,
                                       input logic [7:0] dat, input bit last, input int n);
        m_ov[d] = x;
        if (x) begin
            m_od[d]  = dat;
            m_oc[d]  = g;
            m_ol[d]  = last;
            m_ptr[d] = (g + 1) % n;
            if (LOCK_EN) begin
                m_locked[d]  = !last;
                m_lock_ch[d] = g;
            end
        end
    endfunction

    // One clock: check both DUTs against the model, then advance the model.
    task automatic cycle();
        int g0, g1;
        bit v0, v1, ld0, ld1, x0, x1, l0, l1;
        logic [3:0] er0;
        logic [2:0] er1;
        logic [7:0] d0, d1;
        #1;
        model_grant(0, rr_valid, 0, g0, v0);
        model_grant(1, {1'b0, sl_valid}, int'(sl_sel), g1, v1);
        ld0 = !m_ov[0] || rr_oready;
        ld1 = !m_ov[1] || sl_oready;
        x0  = !rst && ld0 && v0;
        x1  = !rst && ld1 && v1;
        er0 = x0 ? 4'(1 << g0) : 4'd0;
        er1 = x1 ? 3'(1 << g1) : 3'd0;
        d0  = rr_data[g0*8 +: 8];
        d1  = sl_data[g1*8 +: 8];
        l0  = LOCK_EN ? rr_last[g0] : 1'b0;
        l1  = LOCK_EN ? sl_last[g1] : 1'b0;
        check("rr_in_ready", 32'(rr_ready), 32'(er0));
        check("rr_out_valid", 32'(rr_ovalid), 32'(m_ov[0]));
        check("rr_out_data", 32'(rr_odata), 32'(m_od[0]));
        check("rr_out_ch", 32'(rr_och), 32'(m_oc[0]));
        check("sl_in_ready", 32'(sl_ready), 32'(er1));
        check("sl_out_valid", 32'(sl_ovalid), 32'(m_ov[1]));
        check("sl_out_data", 32'(sl_odata), 32'(m_od[1]));
        check("sl_out_ch", 32'(sl_och), 32'(m_oc[1]));
        if (LOCK_EN) begin
            check("rr_out_last", 32'(rr_olast), 32'(m_ol[0]));
            check("sl_out_last", 32'(sl_olast), 32'(m_ol[1]));
        end
        rr_acc = er0;
        sl_acc = er1;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (ld0) model_take(0, x0, g0, d0, l0, 4);
            if (ld1) model_take(1, x1, g1, d1, l1, 3);
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        rr_valid = 4'hF; rr_data = 32'h13121110; rr_last = 4'hF; rr_sel = 2'd0; rr_oready = 1'b1;
        sl_valid = 3'b000; sl_data = 24'h0; sl_last = 3'h7; sl_sel = 2'd0; sl_oready = 1'b1;
        rr_acc = 4'h0; sl_acc = 3'h0;

        // Reset held two cycles with every channel valid
        @(posedge clk);
        @(negedge clk);
        cycle();
        check("rst_in_ready", 32'(rr_ready), 32'h0);
        check("rst_out_valid", 32'(rr_ovalid), 32'h0);
        check("rst_out_data", 32'(rr_odata), 32'h0);
        check("rst_out_ch", 32'(rr_och), 32'h0);
        cycle();
        rst = 1'b0;

        // Round-robin fairness with everyone valid; select DUT alongside
        sl_sel = 2'd2; sl_valid = 3'b100; sl_data = 24'hA5_0000;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) sl_sel = 2'd3;
            #1;
            if (i == 0) check("sel2_in_ready", 32'(sl_ready), 32'h4);
            if (i == 2) check("sel3_in_ready", 32'(sl_ready), 32'h0);
            cycle();
            check("rr_seq_data", 32'(rr_odata), 32'(8'h10 + 8'(i % 4)));
            check("rr_seq_valid", 32'(rr_ovalid), 32'h1);
            if (i == 0) begin
                check("sel2_out_valid", 32'(sl_ovalid), 32'h1);
                check("sel2_out_data", 32'(sl_odata), 32'hA5);
                check("sel2_out_ch", 32'(sl_och), 32'h2);
            end
            if (i == 2) check("sel3_out_valid", 32'(sl_ovalid), 32'h0);
        end

        // Bring channel 1's beat into the output, then stall the consumer
        cycle();
        cycle();
        check("bp_load", 32'(rr_odata), 32'h11);
        rr_oready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(rr_ready), 32'h0);
            cycle();
            check("bp_hold_data", 32'(rr_odata), 32'h11);
            check("bp_hold_valid", 32'(rr_ovalid), 32'h1);
        end
        rr_oready = 1'b1;
        cycle();
        check("bp_release_ch", 32'(rr_och), 32'h2);

        // Sparse requests: pointer now at 3
        rr_valid = 4'b0010;
        cycle();
        check("sparse_ch1", 32'(rr_och), 32'h1);
        rr_valid = 4'b0011;
        cycle();
        check("sparse_wrap_ch0", 32'(rr_och), 32'h0);

        if (LOCK_EN) begin
            // Three-beat packet on channel 1 while 0 and 2 compete
            rr_valid = 4'b0111;
            rr_last  = 4'b1101;
            for (int b = 0; b < 3; b++) begin
                rr_last[1] = (b == 2);
                rr_data[15:8] = 8'h20 + 8'(b);
                cycle();
                check("pkt_ch", 32'(rr_och), 32'h1);
                check("pkt_last", 32'(rr_olast), 32'(b == 2));
                check("pkt_data", 32'(rr_odata), 32'(8'h20 + 8'(b)));
            end
            cycle();
            check("pkt_after_ch", 32'(rr_och), 32'h2);
            // Open a packet on channel 1, then reset in the middle of it
            rr_valid = 4'b0010;
            rr_last[1] = 1'b0;
            cycle();
            check("midpkt_ch", 32'(rr_och), 32'h1);
            rr_valid = 4'hF;
            rst = 1'b1;
            cycle();
            rst = 1'b0;
            cycle();
            check("rst_unlock_ch", 32'(rr_och), 32'h0);
        end

        // Randomized traffic; a pending beat is held until accepted
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!rr_valid[i] || rr_acc[i]) begin
                    rr_valid[i] = ($urandom_range(0, 3) != 0);
                    rr_data[i*8 +: 8] = 8'($urandom);
                    rr_last[i] = ($urandom_range(0, 1) != 0);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (!sl_valid[i] || sl_acc[i]) begin
                    sl_valid[i] = ($urandom_range(0, 3) != 0);
                    sl_data[i*8 +: 8] = 8'($urandom);
                    sl_last[i] = ($urandom_range(0, 1) != 0);
                end
            end
            rr_oready = ($urandom_range(0, 3) != 0);
            sl_oready = ($urandom_range(0, 3) != 0);
            sl_sel    = 2'($urandom_range(0, 3));
            rr_sel    = 2'($urandom_range(0, 3));
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's combinational 2:1 mux.
- Selects one of N_CH valid/ready input streams of width DATA_W onto a single registered output stream.
- Selection is either an external channel select or internal round-robin arbitration.
- Sits between multi-source producers and a single consumer; one register stage, full throughput.

Parameters:
- N_CH, 4, number of input channels (>=2)
- DATA_W, 8, data width per channel
- MODE, 1, 0 = external select via sel, 1 = round-robin arbitration (sel ignored)
- SEL_W, $clog2(N_CH), width of sel and out_ch

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  N_CH  per-channel valid
- in_ready  output  N_CH  per-channel ready
- in_data  input  N_CH*DATA_W  packed channel data, channel i at [i*DATA_W +: DATA_W]
- sel  input  SEL_W  channel select, used only when MODE=0
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts
- out_data  output  DATA_W  registered selected data
- out_ch  output  SEL_W  index of the channel that produced out_data

Behaviour:
- Reset, synchronous: out_valid=0, out_data=0, out_ch=0, rr pointer=0, lock state cleared. Any held beat is dropped.
- load_en = !out_valid || out_ready. Output stage accepts a new beat whenever empty or draining in the same cycle, giving 1 beat/cycle throughput.
- in_ready is combinational: in_ready[i] = load_en && (i == grant) && grant_vld. At most one bit is set.
- Transfer on channel i when in_valid[i] && in_ready[i]. Next cycle: out_valid=1, out_data=in_data[i], out_ch=i.
- Latency: input transfer to out_valid is exactly 1 cycle.
- If out_valid && out_ready and there is no new transfer, out_valid goes to 0.
- If out_valid && !out_ready, out_valid, out_data and out_ch hold stable, and all in_ready are 0.
- MODE=0:
  - grant = sel; grant_vld = in_valid[sel] && (sel < N_CH).
  - sel >= N_CH selects nothing: all in_ready=0.
  - sel may change any cycle; it only affects the cycle in which it is sampled.
- MODE=1, round-robin:
  - Search channels ptr, ptr+1, ..., wrapping mod N_CH; grant = first channel with in_valid set.
  - grant_vld = |in_valid.
  - On transfer, ptr <= (grant+1) mod N_CH. Wrap N_CH-1 -> 0.
  - ptr is unchanged when there is no transfer, including under backpressure.
- Fairness: with all N_CH channels continuously valid and out_ready=1, the grant order is 0,1,..,N_CH-1,0,...
- Within a channel, data never reorders or duplicates. Upstream in_data must stay stable while in_valid && !in_ready.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- When defined:
  - Adds port in_last (input, N_CH) and port out_last (output, 1, registered with out_data, reset 0).
  - After a transfer with in_last[grant]=0, the grant locks to that channel. Arbitration (or sel in MODE=0) is ignored until a transfer with in_last=1 on that channel; the lock then clears.
  - While locked, other channels get no in_ready even if valid.
  - Reset clears the lock.
- When not defined: no last ports; arbitration is per beat.

Decomposition:
- Package stream_mux_pkg:
  - mode constants MODE_SEL=0, MODE_RR=1
  - function rr_next(ptr, N) for the wrap increment
- Sub-module rr_arbiter: N-bit request vector and pointer in; one-hot grant, grant index and grant_vld out. Purely combinational; the pointer register lives in stream_mux_rr.
- MODE=0 bypasses rr_arbiter via generate.

Test Plan (N_CH=4, DATA_W=8):
- Reset: assert rst 2 cycles with in_valid=4'hF -> out_valid=0, out_data=0, out_ch=0, in_ready=0 during reset; first grant after release is channel 0.
- MODE=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2. sel=3'd5 is not applicable at SEL_W=2; instead use N_CH=3 with sel=3 -> in_ready=0.
- MODE=1, all valid, data ch i = 8'h10+i, out_ready=1 for 8 cycles -> out_data 10,11,12,13,10,11,12,13, one beat/cycle.
- Backpressure: out_valid=1 holding 8'h11, out_ready=0 for 3 cycles -> out_data stable, in_ready=0, ptr unchanged; on release, next grant is channel 2.
- Sparse RR: ptr=3, in_valid=4'b0010 -> channel 1 granted, then ptr=2; next, in_valid=4'b0011 -> channel 0 granted (wrap).
- STREAM_MUX_PKT_LOCK_EN: ch1 sends 3 beats with last on the 3rd while ch0 and ch2 are valid -> out_ch=1,1,1 with out_last=0,0,1, then out_ch=2. Reset mid-packet -> lock cleared, first grant is channel 0.
